instr_fetch_unit: RTL and testbench

// Instruction fetch stage of the 16-bit RISC core. Holds the program counter and issues word fetches to instruction memory over a req/ack handshake.

---
 rtl/risc16_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/instr_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
// Shared constants and types for the risc16 fetch stage: word/address widths,
// reset vector, fetch FSM state encoding and the prefetch queue entry layout.
package risc16_pkg;

  localparam int              DATA_W   = 16;
  localparam int              ADDR_W   = 16;
  localparam logic [15:0]     RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_REQ   = 2'd1,
    IF_FLUSH = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with registered storage; clear overrides push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int                PW       = $clog2(DEPTH);
  localparam logic [PW:0]       FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count != FULL_CNT);
  assign w_do_pop  = i_pop && (r_count != '0);

  // Storage, pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC/request FSM feeding a prefetch queue toward decode.
// Define IF_PERF_CNT_EN to add the o_fetch_count delivered-instruction counter.
module instr_fetch_unit #(
  parameter int                DATA_W     = risc16_pkg::DATA_W,
  parameter int                ADDR_W     = risc16_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = risc16_pkg::RESET_PC,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [DATA_W-1:0] i_imem_rdata,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_instr_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
`ifdef IF_PERF_CNT_EN
  output logic [15:0]       o_fetch_count,
`endif
  input  logic              i_instr_ready
);

  import risc16_pkg::*;

  localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_CNT = CW'(FIFO_DEPTH);

  if_state_t                 r_state;
  if_state_t                 w_state_nxt;
  logic                      r_imem_req;
  logic                      w_req_nxt;
  logic [ADDR_W-1:0]         r_imem_addr;
  logic [ADDR_W-1:0]         w_addr_nxt;
  logic [ADDR_W-1:0]         r_fetch_pc;
  logic [ADDR_W-1:0]         w_fetch_pc_nxt;
  logic [ADDR_W-1:0]         w_pc_inc;
  logic                      w_push;
  logic                      w_pop;
  logic [CW-1:0]             w_count;
  logic [CW-1:0]             w_occ_after;
  logic                      w_full;
  logic                      w_empty;
  logic [ADDR_W+DATA_W-1:0]  w_head;

  // Redirect wins over queue traffic: the clear drops both the push and the pop.
  assign w_pop       = !w_empty && i_instr_ready && !i_redirect_valid;
  assign w_pc_inc    = r_imem_addr + 1'b1;
  assign w_occ_after = w_pop ? w_count : (w_count + 1'b1);

  // FSM, request and PC state registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IF_IDLE;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
      r_fetch_pc  <= RESET_PC;
    end else begin
      r_state     <= w_state_nxt;
      r_imem_req  <= w_req_nxt;
      r_imem_addr <= w_addr_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
    end
  end

  // Next-state logic; the request address only changes when a new request is issued.
  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_imem_req;
    w_addr_nxt     = r_imem_addr;
    w_fetch_pc_nxt = r_fetch_pc;
    w_push         = 1'b0;
    if (i_redirect_valid) begin
      w_fetch_pc_nxt = i_redirect_pc;
      if ((r_state != IF_IDLE) && !i_imem_ack) begin
        w_state_nxt = IF_FLUSH;
      end else begin
        w_state_nxt = IF_REQ;
        w_req_nxt   = 1'b1;
        w_addr_nxt  = i_redirect_pc;
      end
    end else begin
      case (r_state)
        IF_IDLE: begin
          if (!w_full) begin
            w_state_nxt = IF_REQ;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = r_fetch_pc;
          end else begin
            w_state_nxt = IF_IDLE;
          end
        end
        IF_REQ: begin
          if (i_imem_ack) begin
            w_push         = 1'b1;
            w_fetch_pc_nxt = w_pc_inc;
            if (w_occ_after < DEPTH_CNT) begin
              w_addr_nxt = w_pc_inc;
            end else begin
              w_state_nxt = IF_IDLE;
              w_req_nxt   = 1'b0;
            end
          end else begin
            w_state_nxt = IF_REQ;
          end
        end
        IF_FLUSH: begin
          if (i_imem_ack) begin
            w_state_nxt = IF_REQ;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = r_fetch_pc;
          end else begin
            w_state_nxt = IF_FLUSH;
          end
        end
        default: begin
          w_state_nxt = IF_IDLE;
          w_req_nxt   = 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (i_redirect_valid),
    .i_wdata ({r_imem_addr, i_imem_rdata}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_imem_addr;
  assign o_instr_valid = !w_empty;
  assign o_instr_pc    = w_head[ADDR_W+DATA_W-1:DATA_W];
  assign o_instr       = w_head[DATA_W-1:0];

`ifdef IF_PERF_CNT_EN
  logic [15:0] r_fetch_count;

  // Delivered-instruction counter; survives redirects, wraps naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fetch_count <= 16'd0;
    end else if (w_pop) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end else begin
      r_fetch_count <= r_fetch_count;
    end
  end

  assign o_fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, streaming, backpressure, redirects, wrap.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif

  int n_pass;
  int n_total;

  instr_fetch_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_ack       (imem_ack),
    .i_imem_rdata     (imem_rdata),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_instr_valid    (instr_valid),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc),
`ifdef IF_PERF_CNT_EN
    .o_fetch_count    (fetch_count),
`endif
    .i_instr_ready    (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    instr_ready = 1'b0;

    // 1: reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", {16'd0, imem_addr}, 32'h0000);
    chk("rel_valid", {31'd0, instr_valid}, 32'd0);
    chk("rel_instr", {16'd0, instr}, 32'h0000);
    chk("rel_pc", {16'd0, instr_pc}, 32'h0000);

    // 2: streaming, one word per cycle
    imem_ack = 1'b1;
    instr_ready = 1'b1;
    imem_rdata = 16'hA000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("str_valid", {31'd0, instr_valid}, 32'd1);
      chk("str_pc", {16'd0, instr_pc}, i);
      chk("str_instr", {16'd0, instr}, 32'h0000A000 + i);
      chk("str_addr", {16'd0, imem_addr}, i + 1);
      imem_rdata = 16'hA000 + 16'(i + 1);
    end

    // 3: backpressure after a fresh reset
    rst_n = 1'b0;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("bp_addr0", {16'd0, imem_addr}, 32'h0000);
    imem_ack = 1'b1;
    imem_rdata = 16'hA000;
    tick();
    chk("bp_req1", {31'd0, imem_req}, 32'd1);
    chk("bp_addr1", {16'd0, imem_addr}, 32'h0001);
    imem_rdata = 16'hA001;
    tick();
    chk("bp_req_drop", {31'd0, imem_req}, 32'd0);
    chk("bp_head", {16'd0, instr_pc}, 32'h0000);
    imem_ack = 1'b0;
    tick();
    chk("bp_req_idle", {31'd0, imem_req}, 32'd0);
    chk("bp_hold_head", {16'd0, instr}, 32'h0000A000);
    instr_ready = 1'b1;
    tick();
    chk("bp_pop1_pc", {16'd0, instr_pc}, 32'h0001);
    chk("bp_pop1_instr", {16'd0, instr}, 32'h0000A001);
    tick();
    chk("bp_empty", {31'd0, instr_valid}, 32'd0);
    chk("bp_resume_req", {31'd0, imem_req}, 32'd1);
    chk("bp_resume_addr", {16'd0, imem_addr}, 32'h0002);

    // 4: redirect while a request is outstanding
    imem_ack = 1'b1;
    imem_rdata = 16'hA002;
    tick();
    imem_rdata = 16'hA003;
    tick();
    imem_rdata = 16'hA004;
    tick();
    imem_ack = 1'b0;
    chk("rd_addr5", {16'd0, imem_addr}, 32'h0005);
    tick();
    chk("rd_drained", {31'd0, instr_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    chk("rd_hold_req", {31'd0, imem_req}, 32'd1);
    chk("rd_hold_addr", {16'd0, imem_addr}, 32'h0005);
    tick();
    chk("rd_hold_addr2", {16'd0, imem_addr}, 32'h0005);
    imem_ack = 1'b1;
    imem_rdata = 16'hDEAD;
    tick();
    chk("rd_discard", {31'd0, instr_valid}, 32'd0);
    chk("rd_new_addr", {16'd0, imem_addr}, 32'h0040);
    chk("rd_new_req", {31'd0, imem_req}, 32'd1);
    imem_rdata = 16'hA040;
    tick();
    chk("rd_first_valid", {31'd0, instr_valid}, 32'd1);
    chk("rd_first_pc", {16'd0, instr_pc}, 32'h0040);
    chk("rd_first_instr", {16'd0, instr}, 32'h0000A040);

    // 5: redirect coincident with ack and pop
    imem_rdata = 16'hA041;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0080;
    tick();
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    chk("co_valid", {31'd0, instr_valid}, 32'd0);
    chk("co_addr", {16'd0, imem_addr}, 32'h0080);
    chk("co_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk("co_no_stale", {31'd0, instr_valid}, 32'd0);
    chk("co_addr_hold", {16'd0, imem_addr}, 32'h0080);
`ifdef IF_PERF_CNT_EN
    chk("cnt_before", {16'd0, fetch_count}, 32'd5);
`endif

    // 6: redirect to FFFF with same-cycle ack, then wrap
    imem_ack = 1'b1;
    imem_rdata = 16'hBEEF;
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    chk("wr_addr", {16'd0, imem_addr}, 32'h0000FFFF);
    chk("wr_valid0", {31'd0, instr_valid}, 32'd0);
    imem_rdata = 16'h5FFF;
    tick();
    chk("wr_pc_ffff", {16'd0, instr_pc}, 32'h0000FFFF);
    chk("wr_instr_ffff", {16'd0, instr}, 32'h00005FFF);
    chk("wr_addr_wrap", {16'd0, imem_addr}, 32'h0000);
    imem_rdata = 16'h6000;
    tick();
    chk("wr_pc_0000", {16'd0, instr_pc}, 32'h0000);
    chk("wr_instr_0000", {16'd0, instr}, 32'h00006000);
    chk("wr_addr_next", {16'd0, imem_addr}, 32'h0001);
    imem_ack = 1'b0;
    tick();
    chk("wr_drained", {31'd0, instr_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("cnt_after", {16'd0, fetch_count}, 32'd7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
